tsqr_r_drain: RTL

Downstream readout stage for the single-core TSQR engine. After the engine signals completion on `tsqr_fi`, this block reads the `MATRIX_WIDTH` rows of the upper-triangular R factor through the engine's DMA read port (`dma_mem_*`). It returns them as a back-pressured valid/ready stream, one 512-bit row per beat, for the host DMA / result writer. A credit-limited 4-entry output FIFO absorbs memory read latency, so no row is dropped under back-pressure.

---
 rtl/tsqr_drain_pkg.sv | 14 +
 rtl/tsqr_drain_fifo.sv | 50 +++++
 rtl/tsqr_r_drain.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tsqr_drain_pkg.sv
// Shared types and constants for the TSQR R-factor drain stage.
package tsqr_drain_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } state_e;

    localparam int unsigned LANE_W     = 64;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/tsqr_drain_fifo.sv
// Small synchronous FIFO (FIFO_DEPTH entries) with occupancy count; head is shown combinationally.
module tsqr_drain_fifo
    import tsqr_drain_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic [FIFO_CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (i_wr_en && !i_rd_en) begin
                r_count <= r_count + FIFO_CNT_W'(1);
            end else if (!i_wr_en && i_rd_en) begin
                r_count <= r_count - FIFO_CNT_W'(1);
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/tsqr_r_drain.sv
// Reads the R factor rows out of the TSQR engine memory and streams them with valid/ready.
// Optional TSQR_DRAIN_UPPER_MASK_EN zeroes the lanes below the diagonal before buffering.
module tsqr_r_drain
    import tsqr_drain_pkg::*;
#(
    parameter int unsigned               MATRIX_WIDTH   = 8,
    parameter int unsigned               RAM_WIDTH      = 512,
    parameter int unsigned               RAM_ADDR_WIDTH = 8,
    parameter int unsigned               MEM_NO         = 2,
    parameter int unsigned               MEM_SEL        = 0,
    parameter logic [RAM_ADDR_WIDTH-1:0] R_BASE_ADDR    = '0,
    parameter int unsigned               RD_LAT         = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tsqr_fi,
    output logic [MEM_NO-1:0]               dma_mem_enb,
    output logic [RAM_ADDR_WIDTH-1:0]       dma_mem_addrb,
    input  logic [RAM_WIDTH-1:0]            dma_mem_doutb,
    output logic                            r_valid,
    input  logic                            r_ready,
    output logic [RAM_WIDTH-1:0]            r_data,
    output logic [$clog2(MATRIX_WIDTH)-1:0] r_row,
    output logic                            r_last,
    output logic                            busy,
    output logic                            done,
    output logic                            start_err
);

    localparam int unsigned       ROW_W    = $clog2(MATRIX_WIDTH);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(MATRIX_WIDTH - 1);
    localparam int unsigned       CRED_W   = FIFO_CNT_W + 1;

    state_e                   r_state;
    state_e                   w_state_d;
    logic                     r_fi_q;
    logic                     w_fi_rise;
    logic [ROW_W-1:0]         r_issue_row;
    logic                     w_issue;
    logic [RD_LAT-1:0]        r_pipe_vld;
    logic [ROW_W-1:0]         r_pipe_tag [RD_LAT];
    logic [FIFO_CNT_W-1:0]    w_fifo_cnt;
    logic [CRED_W-1:0]        w_used;
    logic                     w_credit_ok;
    logic                     w_hs;
    logic                     w_done_d;
    logic                     w_wr_en;
    logic [ROW_W-1:0]         w_wr_tag;
    logic [RAM_WIDTH-1:0]     w_wr_data;
    logic [ROW_W+RAM_WIDTH-1:0] w_rd_payload;
    logic                     r_done;
    logic                     r_start_err;

    assign w_fi_rise = tsqr_fi & ~r_fi_q;
    assign w_hs      = r_valid & r_ready;
    assign w_wr_en   = r_pipe_vld[RD_LAT-1];
    assign w_wr_tag  = r_pipe_tag[RD_LAT-1];

    // Every read in flight already owns a FIFO slot, so the FIFO can never overflow.
    always_comb begin
        w_used = CRED_W'(w_fifo_cnt);
        for (int i = 0; i < int'(RD_LAT); i++) begin
            w_used = w_used + CRED_W'(r_pipe_vld[i]);
        end
    end
    assign w_credit_ok = (w_used < CRED_W'(FIFO_DEPTH));

    always_comb begin
        w_state_d = r_state;
        w_issue   = 1'b0;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_fi_rise) w_state_d = StRead;
            end
            StRead: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (r_issue_row == LAST_ROW) w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (w_hs && r_last) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_fi_q      <= 1'b0;
            r_issue_row <= '0;
            r_pipe_vld  <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_pipe_tag[i] <= '0;
            end
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_fi_q      <= tsqr_fi;
            r_done      <= w_done_d;
            r_start_err <= w_fi_rise & (r_state != StIdle);
            if (r_state == StIdle && w_fi_rise) begin
                r_issue_row <= '0;
            end else if (w_issue) begin
                r_issue_row <= r_issue_row + ROW_W'(1);
            end
            for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
            r_pipe_vld[0] <= w_issue;
            r_pipe_tag[0] <= r_issue_row;
        end
    end

    always_comb begin
        dma_mem_enb          = '0;
        dma_mem_enb[MEM_SEL] = w_issue;
    end
    assign dma_mem_addrb = w_issue ? (R_BASE_ADDR + RAM_ADDR_WIDTH'(r_issue_row)) : '0;

`ifdef TSQR_DRAIN_UPPER_MASK_EN
    localparam int unsigned LANES = RAM_WIDTH / LANE_W;

    // Lane 0 sits in the MSBs; lanes left of the diagonal are cleared.
    always_comb begin
        w_wr_data = dma_mem_doutb;
        for (int j = 0; j < int'(LANES); j++) begin
            if (j < int'(w_wr_tag)) begin
                w_wr_data[RAM_WIDTH-1-j*LANE_W -: LANE_W] = '0;
            end
        end
    end
`else
    assign w_wr_data = dma_mem_doutb;
`endif

    tsqr_drain_fifo #(
        .DATA_W(ROW_W + RAM_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_en  (w_wr_en),
        .i_wr_data({w_wr_tag, w_wr_data}),
        .i_rd_en  (w_hs),
        .o_rd_data(w_rd_payload),
        .o_count  (w_fifo_cnt)
    );

    assign r_valid   = (w_fifo_cnt != '0);
    assign r_data    = w_rd_payload[RAM_WIDTH-1:0];
    assign r_row     = w_rd_payload[ROW_W+RAM_WIDTH-1:RAM_WIDTH];
    assign r_last    = r_valid & (r_row == LAST_ROW);
    assign busy      = (r_state != StIdle);
    assign done      = r_done;
    assign start_err = r_start_err;

endmodule
